order_tx_sched: RTL and testbench
=================================

ORDER_TX_SCHED -- requirements
Module: order_tx_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 4, idle cycles enforced between frames when ORDER_GAP_EN is defined.
REQ-002 Parameter TIMEOUT_CYCLES, default 8, maximum cycles from launch to frame_last.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 req  input  4  per-requester order pending; level, held until matching grant.
REQ-006 tready  input  1  downstream AXI-Stream ready; the payload builder does not honour it, so it gates launch only.
REQ-007 frame_last  input  1  tlast from the payload builder.
REQ-008 seq_load  input  1  load request for the sequence counter.
REQ-009 seq_init  input  32  value loaded on seq_load.
REQ-010 grant  output  4  one-hot, one-cycle pulse to the launched requester.
REQ-011 sel  output  2  index of the launched requester; steers the field mux; stable from launch to return to IDLE.
REQ-012 pld_enable  output  1  one-cycle launch pulse to the payload builder.
REQ-013 msg_seq_num  output  32  MsgSeqNum for the current frame.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  sticky flag; frame_last missed.

Function
REQ-016 States: IDLE, WAIT_LAST, GAP; all outputs registered.
REQ-017 IDLE, seq_load=1: load msg_seq_num<=seq_init; no launch that cycle; seq_load outside IDLE is ignored.
REQ-018 IDLE, seq_load=0, |req=1, tready=1: next cycle grant[i]=1, pld_enable=1, sel=i, busy=1, state WAIT_LAST.
REQ-019 IDLE with tready=0 or req=0: no launch; outputs hold.
REQ-020 Arbitration: round-robin; the winner is the first set req index at or after pointer ptr, scanning upward mod 4; ptr<=winner+1 mod 4 on launch.
REQ-021 msg_seq_num is stable during the pld_enable cycle and changes only in IDLE (load) or on frame completion.
REQ-022 WAIT_LAST: a cycle counter starts at 1 in the pld_enable cycle; frame_last=1 -> msg_seq_num+1 (wrap 0xFFFFFFFF->0), leave WAIT_LAST.
REQ-023 Nominal frame: frame_last arrives 4 cycles after the pld_enable cycle.
REQ-024 Counter reaches TIMEOUT_CYCLES without frame_last: timeout_err<=1, no increment, leave WAIT_LAST.
REQ-025 frame_last outside WAIT_LAST is ignored.
REQ-026 Requests dropped before grant are simply not served; no queueing in this block.

Reset
REQ-027 resetn=0 at a clock edge: state IDLE, ptr=0, grant=0, sel=0, pld_enable=0, busy=0, timeout_err=0, msg_seq_num=1.
REQ-028 Reset mid-frame aborts the frame with no sequence increment; reset has priority over every other input.

Configuration
REQ-029 Macro ORDER_GAP_EN defined: after WAIT_LAST exit, enter GAP for exactly GAP_CYCLES cycles with busy=1, then IDLE.
REQ-030 ORDER_GAP_EN undefined: WAIT_LAST exits directly to IDLE; GAP state and GAP_CYCLES are unused.

Verification
REQ-031 After reset, req=4'b0001, tready=1; frame_last 4 cycles after pld_enable -> grant=0001, sel=0, msg_seq_num=1 at launch, then 2.
REQ-032 req=4'b1111 held, tready=1, continuous frames -> grants 0001,0010,0100,1000,0001; msg_seq_num 1..5.
REQ-033 seq_load=1, seq_init=0xFFFFFFFF in IDLE, then one frame -> launches with 0xFFFFFFFF; msg_seq_num=0 after frame_last.
REQ-034 req=0001, tready=0 for 10 cycles then 1 -> no pld_enable during the stall; launch on the cycle after tready rises.
REQ-035 frame_last withheld -> timeout_err=1 after 8 cycles, msg_seq_num unchanged, busy falls; resetn=0 clears timeout_err.
REQ-036 ORDER_GAP_EN defined, GAP_CYCLES=4, req held -> exactly 4 busy GAP cycles between frame_last and the next IDLE cycle; undefined -> none.

Source files
------------

// File: rtl/order_tx_sched.sv
// Order frame launch scheduler: round-robin grant, frame watchdog, MsgSeqNum.
// Define ORDER_GAP_EN to insert GAP_CYCLES busy idle cycles after each frame.
module order_tx_sched #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic        tready,
  input  logic        frame_last,
  input  logic        seq_load,
  input  logic [31:0] seq_init,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        pld_enable,
  output logic [31:0] msg_seq_num,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LAST,
    GAP
  } state_t;

  // One counter serves both the frame watchdog and the gap timer.
  localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ?
                        TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    grant_d;
  logic [1:0]    sel_d;
  logic          pld_d;
  logic [31:0]   seq_d;
  logic          busy_d;
  logic          err_d;
  logic          leave;

  logic          win_found;
  logic [1:0]    win_idx;
  logic [1:0]    idx;

  // Round-robin pick: first pending request at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    pld_d   = 1'b0;
    sel_d   = sel;
    seq_d   = msg_seq_num;
    busy_d  = busy;
    err_d   = timeout_err;
    leave   = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_load) begin
          seq_d = seq_init;
        end else if (win_found && tready) begin
          state_d = WAIT_LAST;
          grant_d = 4'(1) << win_idx;
          sel_d   = win_idx;
          pld_d   = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = win_idx + 2'd1;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LAST: begin
        if (frame_last) begin
          seq_d = msg_seq_num + 32'd1;
          leave = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          err_d = 1'b1;
          leave = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (leave) begin
`ifdef ORDER_GAP_EN
      state_d = GAP;
      cnt_d   = CW'(1);
`else
      state_d = IDLE;
      busy_d  = 1'b0;
`endif
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant       <= '0;
      sel         <= '0;
      pld_enable  <= 1'b0;
      msg_seq_num <= 32'd1;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant       <= grant_d;
      sel         <= sel_d;
      pld_enable  <= pld_d;
      msg_seq_num <= seq_d;
      busy        <= busy_d;
      timeout_err <= err_d;
    end
  end

endmodule

// File: tb/tb_order_tx_sched.sv
// Scoreboard bench for order_tx_sched: randomized frames vs. a
// transaction-level model of arbitration, sequence numbers and timing.
module tb_order_tx_sched;

  localparam int TMO = 8;
`ifdef ORDER_GAP_EN
  localparam int GAPX = 4;
`else
  localparam int GAPX = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req = '0;
  logic        tready = 1'b0;
  logic        frame_last = 1'b0;
  logic        seq_load = 1'b0;
  logic [31:0] seq_init = '0;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        pld_enable;
  logic [31:0] msg_seq_num;
  logic        busy;
  logic        timeout_err;

  order_tx_sched #(
    .GAP_CYCLES(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .tready(tready),
    .frame_last(frame_last),
    .seq_load(seq_load),
    .seq_init(seq_init),
    .grant(grant),
    .sel(sel),
    .pld_enable(pld_enable),
    .msg_seq_num(msg_seq_num),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  g;
    logic [1:0]  s;
    logic [31:0] q;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int          m_ptr;
  logic [31:0] m_seq;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every launch pulse must match the oldest expected launch.
  always @(negedge clk) begin
    if (resetn && pld_enable) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: got grant %b expected none",
                 grant);
      end else begin
        mon_e = sbq.pop_front();
        chk("grant", {28'd0, grant}, {28'd0, mon_e.g});
        chk("sel", {30'd0, sel}, {30'd0, mon_e.s});
        chk("seq_at_launch", msg_seq_num, mon_e.q);
        chk("busy_at_launch", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    tready = 1'b0;
    frame_last = 1'b0;
    seq_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_pld", {31'd0, pld_enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_seq", msg_seq_num, 32'd1);
    sbq.delete();
    m_ptr = 0;
    m_seq = 32'd1;
    m_err = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic do_load(input logic [31:0] v);
    seq_load = 1'b1;
    seq_init = v;
    @(negedge clk);
    seq_load = 1'b0;
    m_seq = v;
    chk("seq_load", msg_seq_num, v);
  endtask

  function automatic int rr_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One frame: stall, launch, optional frame_last after d cycles.
  task automatic frame(input logic [3:0] r, input int stall,
                       input int d, input bit tmo);
    int   w;
    int   lat;
    int   cnt;
    int   guard;
    exp_t x;
    w = rr_winner(r, m_ptr);
    x.g = 4'(1 << w);
    x.s = 2'(w);
    x.q = m_seq;
    req = r;
    tready = 1'b0;
    repeat (stall) @(negedge clk);
    sbq.push_back(x);
    tready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!pld_enable && lat < 10);
    chk("launch_latency", lat, 1);
    if (!pld_enable) return;
    m_ptr = (w + 1) % 4;
    req = '0;
    tready = 1'($urandom_range(0, 1));
    seq_load = 1'($urandom_range(0, 1));
    seq_init = $urandom;
    cnt = 1;
    if (!tmo) begin
      for (int k = 0; k <= d; k++) begin
        if (k > 0) begin
          @(negedge clk);
          seq_load = 1'b0;
          if (busy) cnt++;
        end
        if (k == d) frame_last = 1'b1;
      end
      m_seq = m_seq + 32'd1;
    end else begin
      m_err = 1'b1;
    end
    guard = 0;
    while (guard < 60) begin
      @(negedge clk);
      frame_last = 1'b0;
      seq_load = 1'b0;
      if (!busy) break;
      cnt++;
      guard++;
    end
    tready = 1'b0;
    chk("busy_cycles", cnt, (tmo ? TMO : d + 1) + GAPX);
    chk("seq_after", msg_seq_num, m_seq);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
    chk("sel_hold", {30'd0, sel}, 32'(w));
    chk("grant_idle", {28'd0, grant}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] r;
    exp_t       x;
    int         w;
    int         lat;
    do_reset();
    frame(4'b0001, 0, 4, 1'b0);

    do_reset();
    for (int i = 0; i < 5; i++) frame(4'b1111, 0, 4, 1'b0);

    do_load(32'hFFFF_FFFF);
    frame(4'b0010, 0, 4, 1'b0);
    chk("wrap_zero", msg_seq_num, 32'd0);

    frame(4'b0001, 10, 4, 1'b0);

    frame(4'b0001, 0, 0, 1'b1);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0)
        do_load(($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom);
      r = 4'($urandom_range(1, 15));
      frame(r, $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        frame_last = 1'b1;
        @(negedge clk);
        frame_last = 1'b0;
        chk("idle_last_ignored", msg_seq_num, m_seq);
      end
    end

    // Reset in the middle of a frame, then confirm ptr restarted at 0.
    w = rr_winner(4'b0100, m_ptr);
    x.g = 4'(1 << w);
    x.s = 2'(w);
    x.q = m_seq;
    sbq.push_back(x);
    req = 4'b0100;
    tready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!pld_enable && lat < 10);
    chk("mid_launch_latency", lat, 1);
    req = '0;
    repeat (2) @(negedge clk);
    do_reset();
    frame(4'b1111, 0, 4, 1'b0);

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
